// File: rtl/operand_stage.sv
// Register-read and issue stage: small register file with write-back bypass,
// pending-write scoreboard interlock and a valid/ready output register.
module operand_stage #(
  parameter int DATA_W    = 8,
  parameter int REG_COUNT = 4,
  parameter int ADDR_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_wen,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_alu_src,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_wen,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush
);

  logic [DATA_W-1:0]    regs_q [REG_COUNT];
  logic [REG_COUNT-1:0] pend_q, pend_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_a_q, out_a_d;
  logic [DATA_W-1:0] out_b_q, out_b_d;
  logic [DATA_W-1:0] out_imm_q, out_imm_d;
  logic              out_src_q, out_src_d;
  logic [ADDR_W-1:0] out_rd_q, out_rd_d;
  logic              out_wen_q, out_wen_d;

  logic              hit_a, hit_b, hit_d;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic              haz_a, haz_b, haz_d, hazard;
  logic              accept;

  assign hit_a = wb_en && (wb_addr == in_rs);
  assign hit_b = wb_en && (wb_addr == in_rt);
  assign hit_d = wb_en && (wb_addr == in_rd);

  // r0 is hardwired to zero even when a write-back targets it
  assign rd_a = (in_rs == '0) ? '0 : (hit_a ? wb_data : regs_q[in_rs]);
  assign rd_b = (in_rt == '0) ? '0 : (hit_b ? wb_data : regs_q[in_rt]);

  assign haz_a = (in_rs != '0) && pend_q[in_rs] && !hit_a;
  assign haz_b = !in_use_imm && (in_rt != '0) && pend_q[in_rt] && !hit_b;
  assign haz_d = in_wen && (in_rd != '0) && pend_q[in_rd] && !hit_d;
  assign hazard = haz_a || haz_b || haz_d;

  assign in_ready = !rst && !flush && !hazard
                    && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    pend_d = pend_q;
    if (wb_en) pend_d[wb_addr] = 1'b0;
    if (flush && out_valid_q && out_wen_q) pend_d[out_rd_q] = 1'b0;
    // a new writer's set takes priority over a same-cycle clear
    if (accept && in_wen) pend_d[in_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_imm_d   = out_imm_q;
    out_src_d   = out_src_q;
    out_rd_d    = out_rd_q;
    out_wen_d   = out_wen_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_a_d     = rd_a;
      out_b_d     = rd_b;
      out_imm_d   = in_imm;
      out_src_d   = in_use_imm;
      out_rd_d    = in_rd;
      out_wen_d   = in_wen;
    end else if (flush || out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_imm_q   <= '0;
      out_src_q   <= 1'b0;
      out_rd_q    <= '0;
      out_wen_q   <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_imm_q   <= out_imm_d;
      out_src_q   <= out_src_d;
      out_rd_q    <= out_rd_d;
      out_wen_q   <= out_wen_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_imm     = out_imm_q;
  assign out_alu_src = out_src_q;
  assign out_rd      = out_rd_q;
  assign out_wen     = out_wen_q;

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: directed scenarios plus random traffic
// checked against an architectural model of the stage.
module tb_operand_stage;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_rs, in_rt, in_rd;
  logic       in_wen;
  logic [7:0] in_imm;
  logic       in_use_imm;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_a, out_b, out_imm;
  logic       out_alu_src;
  logic [1:0] out_rd;
  logic       out_wen;
  logic       wb_en;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic       flush;

  int total = 0;
  int bad   = 0;

  operand_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_wen(in_wen), .in_imm(in_imm), .in_use_imm(in_use_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_imm(out_imm),
    .out_alu_src(out_alu_src), .out_rd(out_rd), .out_wen(out_wen),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // architectural model
  logic [7:0] m_reg [4] = '{8'h0, 8'h0, 8'h0, 8'h0};
  bit         m_pend [4] = '{0, 0, 0, 0};
  logic       m_ov = 1'b0, m_src = 1'b0, m_wen = 1'b0;
  logic [7:0] m_a = '0, m_b = '0, m_imm = '0;
  logic [1:0] m_rd = '0;

  function automatic logic [7:0] m_read(input logic [1:0] a);
    if (a == 2'd0) return 8'h00;
    if (wb_en && wb_addr == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic logic m_busy(input logic [1:0] a);
    return (a != 2'd0) && m_pend[a] && !(wb_en && wb_addr == a);
  endfunction

  function automatic logic m_ready();
    return !rst && !flush && !m_busy(in_rs)
           && !(!in_use_imm && m_busy(in_rt))
           && !(in_wen && m_busy(in_rd))
           && (!m_ov || out_ready);
  endfunction

  function automatic logic [28:0] m_vec();
    return {m_ov, m_a, m_b, m_imm, m_src, m_rd, m_wen};
  endfunction

  task automatic model_edge();
    logic acc;
    logic [7:0] ra, rb;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_reg[i] = 8'h00;
        m_pend[i] = 0;
      end
      m_ov = 0; m_a = 0; m_b = 0; m_imm = 0;
      m_src = 0; m_rd = 0; m_wen = 0;
    end else begin
      acc = in_valid && m_ready();
      ra = m_read(in_rs);
      rb = m_read(in_rt);
      if (wb_en) begin
        if (wb_addr != 2'd0) m_reg[wb_addr] = wb_data;
        m_pend[wb_addr] = 0;
      end
      if (flush && m_ov && m_wen) m_pend[m_rd] = 0;
      if (acc) begin
        m_ov = 1; m_a = ra; m_b = rb; m_imm = in_imm;
        m_src = in_use_imm; m_rd = in_rd; m_wen = in_wen;
        if (in_wen && in_rd != 2'd0) m_pend[in_rd] = 1;
      end else if (flush || (m_ov && out_ready)) begin
        m_ov = 0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0;
    in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0;
    in_wen = 0; in_imm = 0; in_use_imm = 0;
    out_ready = 1;
    wb_en = 0; wb_addr = 0; wb_data = 0;
  endtask

  function automatic logic [28:0] dut_vec();
    return {out_valid, out_a, out_b, out_imm, out_alu_src, out_rd, out_wen};
  endfunction

  task automatic test_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b want=1", in_ready);
    end
    total++;
    if (dut_vec() !== 29'd0) begin
      bad++; $display("FAIL reset_outs got=%h want=0", dut_vec());
    end
  endtask

  task automatic test_rf_basic();
    idle();
    wb_en = 1; wb_addr = 1; wb_data = 8'h3C;
    tick();
    wb_addr = 2; wb_data = 8'hA5;
    tick();
    wb_en = 0;
    in_valid = 1; in_rs = 1; in_rt = 2;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL basic_ready got=%b want=1", in_ready);
    end
    tick();
    total++;
    if ({out_valid, out_a, out_b, out_alu_src} !== {1'b1, 8'h3C, 8'hA5, 1'b0}) begin
      bad++;
      $display("FAIL basic_read got=%b/%h/%h/%b want=1/3c/a5/0",
               out_valid, out_a, out_b, out_alu_src);
    end
    idle();
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL basic_consume got=%b want=0", out_valid);
    end
  endtask

  task automatic test_bypass();
    idle();
    wb_en = 1; wb_addr = 3; wb_data = 8'h77;
    in_valid = 1; in_rs = 3;
    tick();
    total++;
    if ({out_valid, out_a} !== {1'b1, 8'h77}) begin
      bad++; $display("FAIL bypass_a got=%b/%h want=1/77", out_valid, out_a);
    end
    idle();
    wb_en = 1; wb_addr = 0; wb_data = 8'hFF;
    tick();
    idle();
    wb_en = 1; wb_addr = 0; wb_data = 8'hFF;
    in_valid = 1; in_rs = 0; in_rt = 0;
    tick();
    total++;
    if ({out_valid, out_a, out_b} !== {1'b1, 8'h00, 8'h00}) begin
      bad++;
      $display("FAIL r0_zero got=%b/%h/%h want=1/00/00", out_valid, out_a, out_b);
    end
    idle();
    tick();
  endtask

  task automatic test_raw();
    idle();
    in_valid = 1; in_wen = 1; in_rd = 2;
    tick();
    in_wen = 0; in_rd = 0; in_rs = 2;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL raw_stall0 got=%b want=0", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL raw_bubble got=%b want=0", out_valid);
    end
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL raw_stall1 got=%b want=0", in_ready);
    end
    wb_en = 1; wb_addr = 2; wb_data = 8'h11;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL raw_release got=%b want=1", in_ready);
    end
    tick();
    total++;
    if ({out_valid, out_a} !== {1'b1, 8'h11}) begin
      bad++; $display("FAIL raw_data got=%b/%h want=1/11", out_valid, out_a);
    end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [28:0] snap;
    idle();
    in_valid = 1; in_rs = 1; in_rt = 2;
    in_imm = 8'($urandom); in_use_imm = 1;
    tick();
    snap = m_vec();
    total++;
    if (dut_vec() !== snap) begin
      bad++; $display("FAIL hold_load got=%h want=%h", dut_vec(), snap);
    end
    out_ready = 0;
    in_rs = 3; in_rt = 1; in_imm = 8'($urandom); in_use_imm = 0;
    repeat (3) begin
      #1;
      total++;
      if (in_ready !== 1'b0) begin
        bad++; $display("FAIL hold_ready got=%b want=0", in_ready);
      end
      tick();
      total++;
      if (dut_vec() !== snap) begin
        bad++; $display("FAIL hold_stable got=%h want=%h", dut_vec(), snap);
      end
    end
    out_ready = 1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_ready got=%b want=1", in_ready);
    end
    tick();
    total++;
    if ({out_valid, out_a, out_b} !== {1'b1, 8'h77, 8'h3C}) begin
      bad++;
      $display("FAIL b2b_data got=%b/%h/%h want=1/77/3c", out_valid, out_a, out_b);
    end
    idle();
    tick();
  endtask

  task automatic test_flush();
    idle();
    in_valid = 1; in_wen = 1; in_rd = 1;
    tick();
    idle();
    out_ready = 0;
    tick();
    total++;
    if ({out_valid, out_rd, out_wen} !== {1'b1, 2'd1, 1'b1}) begin
      bad++;
      $display("FAIL flush_held got=%b/%0d/%b want=1/1/1", out_valid, out_rd, out_wen);
    end
    flush = 1;
    wb_en = 1; wb_addr = 3; wb_data = 8'h5A;
    in_valid = 1; in_rs = 2;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL flush_ready got=%b want=0", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_kill got=%b want=0", out_valid);
    end
    idle();
    in_valid = 1; in_rs = 1; in_rt = 3;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_pend got=%b want=1", in_ready);
    end
    tick();
    total++;
    if ({out_valid, out_a, out_b} !== {1'b1, 8'h3C, 8'h5A}) begin
      bad++;
      $display("FAIL flush_wb got=%b/%h/%h want=1/3c/5a", out_valid, out_a, out_b);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    idle();
    in_valid = 1; in_wen = 1; in_rd = 1;
    tick();
    out_ready = 0; in_rd = 3;
    tick();
    rst = 1;
    wb_en = 1; wb_addr = 2; wb_data = 8'h99;
    tick();
    total++;
    if (dut_vec() !== 29'd0) begin
      bad++; $display("FAIL rstmid_outs got=%h want=0", dut_vec());
    end
    idle();
    in_valid = 1; in_rs = 1; in_rt = 2; in_wen = 1; in_rd = 1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_ready got=%b want=1", in_ready);
    end
    tick();
    total++;
    if ({out_valid, out_a, out_b} !== {1'b1, 8'h00, 8'h00}) begin
      bad++;
      $display("FAIL rstmid_regs got=%b/%h/%h want=1/00/00", out_valid, out_a, out_b);
    end
    in_wen = 0; in_rs = 3; in_rt = 0;
    tick();
    total++;
    if ({out_valid, out_a} !== {1'b1, 8'h00}) begin
      bad++; $display("FAIL rstmid_r3 got=%b/%h want=1/00", out_valid, out_a);
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 49) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      in_valid   = 1'($urandom);
      in_rs      = 2'($urandom);
      in_rt      = 2'($urandom);
      in_rd      = 2'($urandom);
      in_wen     = 1'($urandom);
      in_imm     = 8'($urandom);
      in_use_imm = 1'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      wb_en      = ($urandom_range(0, 2) == 0);
      wb_addr    = 2'($urandom);
      wb_data    = 8'($urandom);
      #1;
      total++;
      if (in_ready !== m_ready()) begin
        bad++;
        $display("FAIL rand_ready n=%0d got=%b want=%b", n, in_ready, m_ready());
      end
      tick();
      total++;
      if (dut_vec() !== m_vec()) begin
        bad++;
        $display("FAIL rand_outs n=%0d got=%h want=%h", n, dut_vec(), m_vec());
      end
    end
    idle();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_rf_basic();
    test_bypass();
    test_raw();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
